byte_mem_ctrl: RTL and testbench
================================

Name: byte_mem_ctrl

Overview:
- Parametrised, byte-addressable single-port memory with a valid/ready request channel and a valid/ready read-response channel.
- Generalises the 32-bit word memory to any multiple-of-8 data width and any power-of-two depth.
- Adds a post-reset zero-clear sweep, registered read responses with backpressure, and defined wrap-around at the top of the address space.
- Sits between a CPU/load-store unit and on-chip storage.

Parameters:
- DATA_W, 32, access width in bits; must be a multiple of 8 and >= 8; NBYTES = DATA_W/8.
- ADDR_W, 10, byte address width; storage holds DEPTH = 2**ADDR_W bytes; DEPTH must be a multiple of NBYTES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; any alignment is legal.
- req_wdata  in  DATA_W  write data, little-endian.
- req_wstrb  in  NBYTES  per-byte write enable; present only with MEM_BYTE_STROBE_EN.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data.

Behaviour:
- States: INIT, IDLE, RESP. req_ready = (state == IDLE). rsp_valid = (state == RESP).
- Reset: rst high at a rising edge forces the following, overriding everything including a pending response:
  - state <= INIT, init_ptr <= 0, rsp_rdata <= 0.
  - The next cycle therefore has req_ready = 0 and rsp_valid = 0.
- INIT:
  - Each cycle, bytes init_ptr .. init_ptr+NBYTES-1 are written with 0, then init_ptr += NBYTES.
  - After DEPTH/NBYTES cycles (256 at defaults) the state becomes IDLE.
  - Requests are not accepted during INIT.
- IDLE, accept: a request is accepted on a rising edge where req_valid && req_ready. Inputs are sampled only on acceptance.
- IDLE, write: for each i in 0..NBYTES-1 whose strobe is set, byte[(req_addr+i) mod DEPTH] <= req_wdata[8i+7:8i] on the accepting edge.
  - State stays IDLE, so writes sustain one per cycle.
  - No response is generated for a write.
- IDLE, read: on the accepting edge, rsp_rdata <= {byte[a+NBYTES-1], ..., byte[a]}, where every index is (req_addr+k) mod DEPTH. State goes to RESP.
  - Latency: rsp_valid is high in the cycle after acceptance.
- RESP:
  - rsp_rdata is held stable and req_ready is 0.
  - On an edge where rsp_ready = 1, state goes to IDLE.
  - Peak read throughput is one read per 2 cycles.
- rsp_rdata keeps its last value after the handshake completes and changes only on the next read acceptance or on reset.
- Wrap-around: address arithmetic is truncated to ADDR_W bits, so an access at DEPTH-1 continues at byte 0.
- Misaligned accesses complete in the same cycle count as aligned ones.
- Read and write can never be simultaneous: one request per handshake, with req_write selecting the operation.
- Reset during RESP drops the response and re-clears all memory.

Optional Feature:
- MEM_BYTE_STROBE_EN:
  - Defined: the req_wstrb port exists and gates each byte of a write. A write with all strobes 0 is accepted and changes nothing.
  - Undefined: the port is absent and every write updates all NBYTES bytes.
  - Read path, FSM and timing are identical in both builds.

Test Plan:
- Init sweep: deassert rst, then count cycles until req_ready rises -> exactly 256 cycles (defaults). Then read 0x3FC -> rsp_rdata = 0x00000000.
- Basic write/read: write 0xDEADBEEF at 0x010, then read 0x010 -> 0xDEADBEEF with rsp_valid one cycle after acceptance. Read 0x011 -> 0x00DEADBE.
- Wrap-around: write 0xA1B2C3D4 at 0x3FE -> read 0x3FE = 0xA1B2C3D4 and read 0x000 = 0x0000A1B2.
- Backpressure: read 0x010 with rsp_ready held 0 for 5 cycles, and a second request presented meanwhile:
  - rsp_valid stays 1, rsp_rdata stays 0xDEADBEEF, req_ready stays 0.
  - The second request is accepted only in the cycle after rsp_ready = 1.
- Strobes: write 0xFFFFFFFF at 0x020, then 0x11223344 with wstrb = 4'b0101 -> read gives 0xFF22FF44 (macro on). With the macro off, the same sequence reads 0x11223344.
- Reset mid-response: assert rst while in RESP after writing 0x12345678 at 0x040:
  - rsp_valid = 0 the next cycle.
  - After the 256-cycle INIT, a read of 0x040 returns 0x00000000.

Source files
------------

// File: rtl/byte_mem_ctrl.sv
// -----------------------------------------------------------------------------
// byte_mem_ctrl
//   Byte-addressable single-port memory with a valid/ready request channel and
//   a valid/ready read-response channel. Any byte alignment is legal. Addresses
//   wrap modulo DEPTH. After reset, the block clears all storage to zero
//   (INIT sweep) before it accepts requests.
//
//   Storage is split into NBYTES byte-wide banks. Byte address b lives in
//   bank b % NBYTES at row b / NBYTES. Each access therefore touches every
//   bank exactly once, whatever its alignment, so misaligned accesses cost
//   nothing extra. Read data is registered per bank and rotated into lane
//   order at the output.
//
// Parameters
//   DATA_W : access width, a multiple of 8 (NBYTES = DATA_W/8)
//   ADDR_W : byte address width, DEPTH = 2**ADDR_W bytes
//
// Build option
//   MEM_BYTE_STROBE_EN : when defined, adds req_wstrb. Each strobe bit gates
//                        one byte lane of a write.
//
// Ports
//   clk, rst                  : clock (rising edge), synchronous active-high reset
//   req_valid / req_ready     : request handshake
//   req_write                 : 1 = write, 0 = read
//   req_addr                  : byte address
//   req_wdata                 : write data, little-endian
//   req_wstrb                 : per-byte write enable (strobe build only)
//   rsp_valid / rsp_ready     : read-response handshake
//   rsp_rdata                 : read data, held until the next read or reset
// -----------------------------------------------------------------------------
module byte_mem_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
`ifdef MEM_BYTE_STROBE_EN
   input  logic [DATA_W/8-1:0] req_wstrb,
`endif
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata
);

   localparam int NBYTES = DATA_W / 8;
   localparam int LOG_NB = $clog2(NBYTES);
   localparam int OFF_W  = (LOG_NB > 0) ? LOG_NB : 1;
   localparam int ROW_W  = ADDR_W - LOG_NB;
   localparam int ROWS   = (2 ** ADDR_W) / NBYTES;

   typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

   state_t             state_reg, state_next;
   logic [ROW_W-1:0]   init_row_reg;        // INIT sweep pointer, in rows of NBYTES bytes
   logic [OFF_W-1:0]   rot_reg;             // alignment of the last accepted read
   logic [OFF_W-1:0]   off;
   logic [NBYTES-1:0]  strb;
   logic               accept, wr_acc, rd_acc;
   logic [7:0]         bank_rd [NBYTES];

   assign req_ready = (state_reg == IDLE);
   assign rsp_valid = (state_reg == RESP);
   assign accept    = req_valid && req_ready;
   assign wr_acc    = accept && req_write;
   assign rd_acc    = accept && !req_write;

   // A single-byte build has only one bank, so the alignment offset is always 0.
   assign off = (LOG_NB > 0) ? req_addr[OFF_W-1:0] : '0;

`ifdef MEM_BYTE_STROBE_EN
   assign strb = req_wstrb;
`else
   assign strb = '1;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= INIT;
         init_row_reg <= '0;
         rot_reg      <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == INIT)
            init_row_reg <= init_row_reg + 1'b1;
         if (rd_acc)
            rot_reg <= off;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         INIT:    if (&init_row_reg) state_next = IDLE;
         IDLE:    if (rd_acc)        state_next = RESP;
         RESP:    if (rsp_ready)     state_next = IDLE;
         default:                    state_next = INIT;
      endcase
   end

   // ---------------------------------------------------------------- banks
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bank
      logic [7:0]       mem [ROWS];
      logic [7:0]       rd_reg;
      logic [OFF_W-1:0] lane;   // byte lane of the current access that maps to this bank
      logic [ROW_W-1:0] row;
      logic [7:0]       wbyte;

      assign lane  = OFF_W'(gi) - off;
      assign row   = ROW_W'((req_addr + ADDR_W'(lane)) >> LOG_NB);
      assign wbyte = req_wdata[8*int'(lane) +: 8];

      always_ff @(posedge clk) begin
         if (!rst) begin
            if (state_reg == INIT)
               mem[init_row_reg] <= '0;
            else if (wr_acc && strb[lane])
               mem[row] <= wbyte;
         end
      end

      always_ff @(posedge clk) begin
         if (rst)
            rd_reg <= '0;
         else if (rd_acc)
            rd_reg <= mem[row];
      end

      assign bank_rd[gi] = rd_reg;
   end

   // Output lane gi comes from the bank that held byte (addr + gi).
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [OFF_W-1:0] sel;
      assign sel = OFF_W'(gi) + rot_reg;
      assign rsp_rdata[8*gi +: 8] = bank_rd[sel];
   end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed testbench for byte_mem_ctrl at default parameters.
// The bench drives inputs on the falling edge and samples outputs there.
module tb_byte_mem_ctrl;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   byte_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef MEM_BYTE_STROBE_EN
      .req_wstrb (req_wstrb),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Wait (bounded) until req_ready is seen high at a falling edge.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
      wait_ready("wr");
      @(negedge clk);
      req_valid = 1'b0;
      $display("wr addr=0x%03h data=0x%08h strb=%b", a, d, s);
   endtask

   // Issue a read, check the response appears one cycle after acceptance, then take it.
   task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      wait_ready("rd");
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_latency", {31'd0, rsp_valid}, 32'd1);
      d = rsp_rdata;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      $display("rd addr=0x%03h data=0x%08h", a, d);
   endtask

   task automatic count_init(input string tag);
      int n = 0;
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n, 32'd256);
   endtask

   logic [31:0] d;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = 4'hF; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      rst = 1'b0;
      count_init("init_cycles");

      do_read(10'h3FC, d);             chk("init_3fc", d, 32'h0000_0000);

      do_write(10'h010, 32'hDEADBEEF, 4'hF);
      do_read(10'h010, d);             chk("rd_010", d, 32'hDEADBEEF);
      do_read(10'h011, d);             chk("rd_011", d, 32'h00DEADBE);
      @(negedge clk);
      chk("rdata_hold", rsp_rdata, 32'h00DEADBE);

      do_write(10'h3FE, 32'hA1B2C3D4, 4'hF);
      do_read(10'h3FE, d);             chk("wrap_3fe", d, 32'hA1B2C3D4);
      do_read(10'h000, d);             chk("wrap_000", d, 32'h0000A1B2);

      // Backpressure: hold rsp_ready low with a second request waiting.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h010;
      wait_ready("bp");
      @(negedge clk);
      req_addr = 10'h011;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_second_rdata", rsp_rdata, 32'h00DEADBE);
      $display("rd addr=0x010 then 0x011 under backpressure data=0x%08h", rsp_rdata);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Byte strobes.
      do_write(10'h020, 32'hFFFFFFFF, 4'hF);
      do_write(10'h020, 32'h11223344, 4'b0101);
      do_read(10'h020, d);
`ifdef MEM_BYTE_STROBE_EN
      chk("strobe", d, 32'hFF22FF44);
`else
      chk("strobe", d, 32'h11223344);
`endif

      // Reset while a response is pending.
      do_write(10'h040, 32'h12345678, 4'hF);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h040;
      wait_ready("mr");
      @(negedge clk);
      req_valid = 1'b0;
      chk("mr_pending", rsp_rdata, 32'h12345678);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mr_req_ready", {31'd0, req_ready}, 32'd0);
      chk("mr_rdata", rsp_rdata, 32'd0);
      rst = 1'b0;
      count_init("mr_init_cycles");
      do_read(10'h040, d);             chk("mr_cleared", d, 32'h0000_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
